result_writeback_unit: RTL and testbench

- Outbound counterpart of the fetch unit. The fetch unit assembles N-word rows into an NxN matrix. This block does the reverse: it captures a finished NxN result matrix from the compute array and streams it out one N-word row per beat.
- Output side is a valid/ready port toward data memory or the host, with an auto-incrementing word-aligned byte address.
- Pulses DONE once the whole matrix has been written.

---
 rtl/roxxon_pkg.sv | 15 +
 rtl/wb_addr_ctr.sv | 32 +++
 rtl/result_writeback_unit.sv | 106 ++++++++++
 tb/tb_result_writeback_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/roxxon_pkg.sv
// Shared types and constants for the result write-back path and the
// address counter it shares with the fetch side.
package roxxon_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      FIN  = 2'd2
   } wb_state_e;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/wb_addr_ctr.sv
// Word-aligned byte pointer with load-to-base, fixed-stride increment and
// wrap inside a region of REGN words starting at ADDR.
module wb_addr_ctr
   import roxxon_pkg::*;
#(
   parameter int          N    = 2,
   parameter logic [31:0] ADDR = 32'h0000_0000,
   parameter int          REGN = 512
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        LOAD,
   input  logic        INC,
   output logic [31:0] PTR
);

   localparam logic [31:0] STEP  = 32'(WORD_BYTES * N);
   localparam logic [31:0] LIMIT = ADDR + 32'(WORD_BYTES * REGN);

   logic [31:0] ptr_nxt;

   // REGN is a multiple of N, so the stride lands exactly on LIMIT
   assign ptr_nxt = PTR + STEP;

   // Load has priority over increment; wrap back to the base at region end
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)          PTR <= ADDR;
      else if (LOAD)      PTR <= ADDR;
      else if (INC)       PTR <= (ptr_nxt == LIMIT) ? ADDR : ptr_nxt;
   end

endmodule

// File: rtl/result_writeback_unit.sv
// Captures an NxN result matrix and streams it out one N-word row per
// valid/ready beat at an auto-incrementing byte address, then pulses DONE.
module result_writeback_unit
   import roxxon_pkg::*;
#(
   parameter int          N    = 2,
   parameter logic [31:0] ADDR = 32'h0000_0000,
   parameter int          REGN = 512
) (
   input  logic                          CLK,
   input  logic                          RSTN,
   input  logic                          RES_VALID,
   output logic                          RES_READY,
   input  logic [N-1:0][N-1:0][31:0]     RES_MAT,
   input  logic                          CLR,
   output logic                          WR_VALID,
   input  logic                          WR_READY,
   output logic [31:0]                   WR_ADDR,
   output logic [N-1:0][31:0]            WR_ROW,
   output logic [$clog2(N)-1:0]          SEQ_R,
   output logic                          DONE
);

   localparam int RW = $clog2(N);
   localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

   wb_state_e             state;
   logic [RW-1:0]         row;
   word_t [N-1:0][N-1:0]  mat_q;
   logic                  res_ready_q;
   logic                  wr_valid_q;
   logic                  done_q;
   logic                  ptr_load;
   logic                  ptr_inc;

   // CLR only matters in IDLE; a beat advances the pointer when accepted
   assign ptr_load = (state == IDLE) && CLR;
   assign ptr_inc  = wr_valid_q && WR_READY;

   wb_addr_ctr #(
      .N    (N),
      .ADDR (ADDR),
      .REGN (REGN)
   ) u_addr_ctr (
      .CLK  (CLK),
      .RSTN (RSTN),
      .LOAD (ptr_load),
      .INC  (ptr_inc),
      .PTR  (WR_ADDR)
   );

   // Control FSM and row buffer; handshake outputs are registered so
   // WR_READY never reaches WR_VALID combinationally
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state       <= IDLE;
         row         <= '0;
         mat_q       <= '0;
         res_ready_q <= 1'b1;
         wr_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (RES_VALID) begin
                  mat_q       <= RES_MAT;
                  row         <= '0;
                  state       <= SEND;
                  res_ready_q <= 1'b0;
                  wr_valid_q  <= 1'b1;
               end
            end
            SEND: begin
               if (WR_READY) begin
                  if (row == LAST_ROW) begin
                     state      <= FIN;
                     wr_valid_q <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     row <= row + RW'(1);
                  end
               end
            end
            FIN: begin
               state       <= IDLE;
               row         <= '0;
               res_ready_q <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               row         <= '0;
               res_ready_q <= 1'b1;
               wr_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign RES_READY = res_ready_q;
   assign WR_VALID  = wr_valid_q;
   assign DONE      = done_q;
   assign WR_ROW    = mat_q[row];
   assign SEQ_R     = row;

endmodule

// File: tb/tb_result_writeback_unit.sv
// Directed table-driven bench for result_writeback_unit (N=2, REGN=8).
module tb_result_writeback_unit;

   localparam int N = 2;

   typedef logic [N-1:0][31:0]        row_t;
   typedef logic [N-1:0][N-1:0][31:0] mat_t;

   typedef struct {
      logic        rv;
      logic        clr;
      logic        wrr;
      mat_t        mat;
      logic        e_rr;
      logic        e_wv;
      logic        e_done;
      logic [31:0] e_addr;
      row_t        e_row;
      logic        e_seq;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b0;
   logic        RES_VALID = 1'b0;
   logic        RES_READY;
   mat_t        RES_MAT = '0;
   logic        CLR = 1'b0;
   logic        WR_VALID;
   logic        WR_READY = 1'b0;
   logic [31:0] WR_ADDR;
   row_t        WR_ROW;
   logic [0:0]  SEQ_R;
   logic        DONE;

   int checks = 0;
   int errors = 0;

   result_writeback_unit #(
      .N    (N),
      .ADDR (32'h0000_0000),
      .REGN (8)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .RES_VALID (RES_VALID),
      .RES_READY (RES_READY),
      .RES_MAT   (RES_MAT),
      .CLR       (CLR),
      .WR_VALID  (WR_VALID),
      .WR_READY  (WR_READY),
      .WR_ADDR   (WR_ADDR),
      .WR_ROW    (WR_ROW),
      .SEQ_R     (SEQ_R),
      .DONE      (DONE)
   );

   always #5 CLK = ~CLK;

   function automatic row_t mk_row(input int hi, input int lo);
      row_t r;
      r[1] = 32'(hi);
      r[0] = 32'(lo);
      return r;
   endfunction

   function automatic mat_t mk_mat(input row_t r1, input row_t r0);
      mat_t m;
      m[1] = r1;
      m[0] = r0;
      return m;
   endfunction

   function automatic vec_t mk_vec(input logic rv, input logic clr, input logic wrr,
                                   input mat_t mat, input logic e_rr, input logic e_wv,
                                   input logic e_done, input logic [31:0] e_addr,
                                   input row_t e_row, input logic e_seq);
      vec_t v;
      v.rv = rv; v.clr = clr; v.wrr = wrr; v.mat = mat;
      v.e_rr = e_rr; v.e_wv = e_wv; v.e_done = e_done;
      v.e_addr = e_addr; v.e_row = e_row; v.e_seq = e_seq;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Compare all outputs; row data and SEQ_R only matter while a beat is valid
   task automatic chk_vec(input string tag, input vec_t v);
      chk({tag, " RES_READY"}, 64'(RES_READY), 64'(v.e_rr));
      chk({tag, " WR_VALID"},  64'(WR_VALID),  64'(v.e_wv));
      chk({tag, " DONE"},      64'(DONE),      64'(v.e_done));
      chk({tag, " WR_ADDR"},   64'(WR_ADDR),   64'(v.e_addr));
      if (v.e_wv) begin
         chk({tag, " WR_ROW"}, 64'(WR_ROW), 64'(v.e_row));
         chk({tag, " SEQ_R"},  64'(SEQ_R),  64'(v.e_seq));
      end
   endtask

   vec_t tv[20];

   initial begin
      mat_t m1, m2, m3, m4;
      row_t z;
      z  = '0;
      m1 = mk_mat(mk_row(4, 3),   mk_row(2, 1));
      m2 = mk_mat(mk_row(8, 7),   mk_row(6, 5));
      m3 = mk_mat(mk_row(12, 11), mk_row(10, 9));
      m4 = mk_mat(mk_row(16, 15), mk_row(14, 13));

      //               rv clr wrr mat  rr wv dn addr         row              seq
      // M1 with three stalled cycles on row1
      tv[0]  = mk_vec(1, 0, 0, m1, 0, 1, 0, 32'h00, mk_row(2, 1),   0);
      tv[1]  = mk_vec(0, 0, 1, m1, 0, 1, 0, 32'h08, mk_row(4, 3),   1);
      tv[2]  = mk_vec(0, 0, 0, m1, 0, 1, 0, 32'h08, mk_row(4, 3),   1);
      tv[3]  = mk_vec(0, 0, 0, m1, 0, 1, 0, 32'h08, mk_row(4, 3),   1);
      tv[4]  = mk_vec(0, 0, 0, m1, 0, 1, 0, 32'h08, mk_row(4, 3),   1);
      tv[5]  = mk_vec(0, 0, 1, m1, 0, 0, 1, 32'h10, z,              0);
      tv[6]  = mk_vec(0, 0, 1, m1, 1, 0, 0, 32'h10, z,              0);
      // M2 back-to-back; M3 + CLR offered during SEND must be ignored
      tv[7]  = mk_vec(1, 0, 1, m2, 0, 1, 0, 32'h10, mk_row(6, 5),   0);
      tv[8]  = mk_vec(1, 1, 1, m3, 0, 1, 0, 32'h18, mk_row(8, 7),   1);
      tv[9]  = mk_vec(0, 0, 1, m3, 0, 0, 1, 32'h00, z,              0);
      tv[10] = mk_vec(0, 0, 1, m3, 1, 0, 0, 32'h00, z,              0);
      // M3 after wrap
      tv[11] = mk_vec(1, 0, 1, m3, 0, 1, 0, 32'h00, mk_row(10, 9),  0);
      tv[12] = mk_vec(0, 0, 1, m3, 0, 1, 0, 32'h08, mk_row(12, 11), 1);
      tv[13] = mk_vec(0, 0, 1, m3, 0, 0, 1, 32'h10, z,              0);
      tv[14] = mk_vec(0, 0, 1, m3, 1, 0, 0, 32'h10, z,              0);
      // CLR together with RES_VALID: M4 starts at base
      tv[15] = mk_vec(1, 1, 1, m4, 0, 1, 0, 32'h00, mk_row(14, 13), 0);
      tv[16] = mk_vec(0, 0, 1, m4, 0, 1, 0, 32'h08, mk_row(16, 15), 1);
      tv[17] = mk_vec(0, 0, 1, m4, 0, 0, 1, 32'h10, z,              0);
      tv[18] = mk_vec(0, 0, 1, m4, 1, 0, 0, 32'h10, z,              0);
      // CLR alone in IDLE
      tv[19] = mk_vec(0, 1, 1, m4, 1, 0, 0, 32'h00, z,              0);

      // Reset state
      #12;
      chk("rst RES_READY", 64'(RES_READY), 64'd1);
      chk("rst WR_VALID",  64'(WR_VALID),  64'd0);
      chk("rst WR_ADDR",   64'(WR_ADDR),   64'd0);
      chk("rst WR_ROW",    64'(WR_ROW),    64'd0);
      chk("rst SEQ_R",     64'(SEQ_R),     64'd0);
      chk("rst DONE",      64'(DONE),      64'd0);
      @(negedge CLK);
      RSTN = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         RES_VALID = tv[i].rv;
         CLR       = tv[i].clr;
         WR_READY  = tv[i].wrr;
         RES_MAT   = tv[i].mat;
         @(posedge CLK);
         #1;
         chk_vec($sformatf("v%0d", i), tv[i]);
      end

      // Asynchronous reset in the middle of SEND
      @(negedge CLK);
      RES_VALID = 1'b1; CLR = 1'b0; WR_READY = 1'b0; RES_MAT = m2;
      @(posedge CLK);
      #1;
      chk("pre-rst WR_VALID", 64'(WR_VALID), 64'd1);
      #2;
      RSTN = 1'b0;
      #1;
      chk("async RES_READY", 64'(RES_READY), 64'd1);
      chk("async WR_VALID",  64'(WR_VALID),  64'd0);
      chk("async WR_ADDR",   64'(WR_ADDR),   64'd0);
      chk("async DONE",      64'(DONE),      64'd0);
      chk("async WR_ROW",    64'(WR_ROW),    64'd0);
      @(negedge CLK);
      RES_VALID = 1'b0;
      RSTN = 1'b1;
      @(posedge CLK);
      #1;
      chk("post-rst RES_READY", 64'(RES_READY), 64'd1);
      chk("post-rst WR_VALID",  64'(WR_VALID),  64'd0);

      // Fresh matrix after reset starts at base, partial matrix not resumed
      @(negedge CLK);
      RES_VALID = 1'b1; WR_READY = 1'b1; RES_MAT = m1;
      @(posedge CLK);
      #1;
      chk("fresh WR_ADDR", 64'(WR_ADDR), 64'd0);
      chk("fresh WR_ROW",  64'(WR_ROW),  64'(mk_row(2, 1)));
      chk("fresh SEQ_R",   64'(SEQ_R),   64'd0);
      @(negedge CLK);
      RES_VALID = 1'b0;
      @(posedge CLK);
      #1;
      chk("fresh r1 WR_ADDR", 64'(WR_ADDR), 64'h8);
      chk("fresh r1 WR_ROW",  64'(WR_ROW),  64'(mk_row(4, 3)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
